// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the stage ALU issuer.
//   - opcode encodings understood by the type-1 ALU
//   - bit positions of the fields inside the action word
//   - issuer FSM state encoding
//   - small opcode-class helpers used when choosing operand 2
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;

    // Action word layout: op | src1/dst | src2 (register ops) or imm (immediate ops).
    localparam int OP_HI   = 24;
    localparam int OP_LO   = 21;
    localparam int SRC1_HI = 20;
    localparam int SRC1_LO = 16;
    localparam int SRC2_HI = 15;
    localparam int SRC2_LO = 11;
    localparam int IMM_W   = 16;

    // Container index width; a PHV holds at most 32 containers.
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

    function automatic logic is_reg_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/phv_container_sel.sv
// phv_container_sel: picks one container out of a flattened PHV bus.
// Ports:
//   phv       in   NUM_CONT*DATA_WIDTH  container i = phv[i*DATA_WIDTH +: DATA_WIDTH]
//   idx       in   IDX_W                container index
//   cont      out  DATA_WIDTH           selected container, 0 when idx is out of range
//   in_range  out  1                    idx addresses a real container
module phv_container_sel
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CONT   = 8
) (
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
    input  logic [IDX_W-1:0]               idx,
    output logic [DATA_WIDTH-1:0]          cont,
    output logic                           in_range
);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cont = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (idx == IDX_W'(i)) begin
                cont = phv[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_range = (int'(idx) < NUM_CONT);

endmodule

// File: rtl/alu_1_issuer.sv
// alu_1_issuer: initiator side of the stage ALU handshake.
// Accepts one PHV with its action word, issues a single request to a type-1
// ALU, waits (bounded) for the container result, writes it back into the
// destination container and presents the updated PHV downstream.
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   phv_in / action_in / phv_in_valid / phv_in_ready     upstream PHV + action
//   alu_action_out / alu_action_valid                    request to the ALU (1-cycle pulse)
//   alu_operand_1_out / alu_operand_2_out                operands, held between issues
//   alu_container_in / alu_container_in_valid            ALU result
//   phv_out / phv_out_valid / phv_out_ready              downstream PHV
//   err_timeout                                          1-cycle pulse, ALU never answered
module alu_1_issuer
    import alu_pkg::*;
#(
    parameter int STAGE_ID   = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CONT   = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]          action_in,
    input  logic                           phv_in_valid,
    output logic                           phv_in_ready,
    output logic [ACTION_LEN-1:0]          alu_action_out,
    output logic                           alu_action_valid,
    output logic [DATA_WIDTH-1:0]          alu_operand_1_out,
    output logic [DATA_WIDTH-1:0]          alu_operand_2_out,
    input  logic [DATA_WIDTH-1:0]          alu_container_in,
    input  logic                           alu_container_in_valid,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
    output logic                           phv_out_valid,
    input  logic                           phv_out_ready,
    output logic                           err_timeout
);

    localparam int PHV_W = NUM_CONT * DATA_WIDTH;
    // One spare count value so the counter can always hold TIMEOUT.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    if (NUM_CONT < 1 || NUM_CONT > 32 || ACTION_LEN < OP_HI + 1 ||
        DATA_WIDTH < IMM_W || STAGE_ID < 0) begin : g_bad_params
        $error("alu_1_issuer: unsupported parameter set");
    end

    state_e                  state_q, state_d;
    logic [PHV_W-1:0]        phv_q, phv_d;
    logic [IDX_W-1:0]        dst_q, dst_d;
    logic [ACTION_LEN-1:0]   act_q, act_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d;
    logic [DATA_WIDTH-1:0]   op2_q, op2_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Decode of the incoming action; only meaningful while phv_in_valid.
    logic [3:0]              in_op;
    logic [IDX_W-1:0]        in_src1;
    logic [IDX_W-1:0]        in_src2;
    logic [DATA_WIDTH-1:0]   in_imm;
    logic [DATA_WIDTH-1:0]   sel1_cont, sel2_cont;
    logic                    sel1_ok, sel2_ok;
    logic                    in_nop;
    logic                    timeout_hit;

    assign in_op   = action_in[OP_HI:OP_LO];
    assign in_src1 = action_in[SRC1_HI:SRC1_LO];
    assign in_src2 = action_in[SRC2_HI:SRC2_LO];
    assign in_imm  = DATA_WIDTH'(action_in[IMM_W-1:0]);

    phv_container_sel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel_src1 (
        .phv      (phv_in),
        .idx      (in_src1),
        .cont     (sel1_cont),
        .in_range (sel1_ok)
    );

    phv_container_sel #(.DATA_WIDTH(DATA_WIDTH), .NUM_CONT(NUM_CONT)) u_sel_src2 (
        .phv      (phv_in),
        .idx      (in_src2),
        .cont     (sel2_cont),
        .in_range (sel2_ok)
    );

    // src2 range only matters for register ops; immediate ops reuse those bits.
    assign in_nop      = !sel1_ok || (in_op == OP_NOP) || (is_reg_op(in_op) && !sel2_ok);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        phv_d   = phv_q;
        dst_d   = dst_q;
        act_d   = act_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (phv_in_valid) begin
                    phv_d = phv_in;
                    dst_d = in_src1;
                    if (in_nop) begin
                        state_d = OUT;
                    end else begin
                        // Request registers load only for a real issue, so a NOP
                        // leaves the previously issued values on the ALU bus.
                        act_d = action_in;
                        op1_d = sel1_cont;
                        if (is_reg_op(in_op)) begin
                            op2_d = sel2_cont;
                        end else if (is_imm_op(in_op)) begin
                            op2_d = in_imm;
                        end else begin
                            op2_d = '0;
                        end
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The result is checked first so it wins over a same-cycle timeout.
                if (alu_container_in_valid) begin
                    for (int i = 0; i < NUM_CONT; i++) begin
                        if (dst_q == IDX_W'(i)) begin
                            phv_d[i*DATA_WIDTH +: DATA_WIDTH] = alu_container_in;
                        end
                    end
                    state_d = OUT;
                end else if (timeout_hit) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (phv_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the PHV holding register is cleared on reset because it drives phv_out directly.
            state_q <= IDLE;
            phv_q   <= '0;
            dst_q   <= '0;
            act_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phv_q   <= phv_d;
            dst_q   <= dst_d;
            act_q   <= act_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phv_in_ready      = (state_q == IDLE);
    assign alu_action_valid  = (state_q == ISSUE);
    assign alu_action_out    = act_q;
    assign alu_operand_1_out = op1_q;
    assign alu_operand_2_out = op2_q;
    assign phv_out           = phv_q;
    assign phv_out_valid     = (state_q == OUT);
    assign err_timeout       = (state_q == WAIT) && timeout_hit && !alu_container_in_valid;

endmodule

// File: tb/tb_alu_1_issuer.sv
`timescale 1ns/1ps
module tb_alu_1_issuer;

    localparam int DW = 48;
    localparam int NC = 8;
    localparam int AL = 25;
    localparam int TO = 15;
    localparam int PW = DW * NC;

    typedef logic [PW-1:0] phv_t;
    typedef logic [DW-1:0] dw_t;
    typedef logic [AL-1:0] act_t;
    typedef struct {
        dw_t  op1;
        dw_t  op2;
        act_t act;
    } issue_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    phv_t phv_in;
    act_t action_in;
    logic phv_in_valid;
    logic phv_in_ready;
    act_t alu_action_out;
    logic alu_action_valid;
    dw_t  alu_operand_1_out;
    dw_t  alu_operand_2_out;
    dw_t  alu_container_in;
    logic alu_container_in_valid;
    phv_t phv_out;
    logic phv_out_valid;
    logic phv_out_ready;
    logic err_timeout;

    alu_1_issuer #(
        .STAGE_ID(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .TIMEOUT(TO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .phv_in                 (phv_in),
        .action_in              (action_in),
        .phv_in_valid           (phv_in_valid),
        .phv_in_ready           (phv_in_ready),
        .alu_action_out         (alu_action_out),
        .alu_action_valid       (alu_action_valid),
        .alu_operand_1_out      (alu_operand_1_out),
        .alu_operand_2_out      (alu_operand_2_out),
        .alu_container_in       (alu_container_in),
        .alu_container_in_valid (alu_container_in_valid),
        .phv_out                (phv_out),
        .phv_out_valid          (phv_out_valid),
        .phv_out_ready          (phv_out_ready),
        .err_timeout            (err_timeout)
    );

    // Input values applied at the next falling edge.
    logic rst_nx   = 1'b1;
    phv_t phv_nx   = '0;
    act_t act_nx   = '0;
    logic valid_nx = 1'b0;
    logic ready_nx = 1'b1;

    // Three-cycle ALU responder.
    logic alu_en  = 1'b1;
    int   alu_cnt = 0;
    dw_t  alu_res = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, n_issue = 0, n_out = 0, n_to = 0, n_acc = 0;
    int acc_cyc = 0, out_cyc = 0, iss_cyc = 0, to_cyc = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    phv_t prev_phv = '0;

    issue_t exp_iss[$];
    phv_t   exp_phv[$];

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic dw_t cont_of(input phv_t p, input int i);
        return p[i*DW +: DW];
    endfunction

    function automatic phv_t set_cont(input phv_t p, input int i, input dw_t v);
        phv_t r = p;
        r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic act_t mk_act(input logic [3:0] op, input logic [4:0] s1, input logic [15:0] low);
        return {op, s1, low};
    endfunction

    function automatic dw_t alu_fn(input logic [3:0] op, input dw_t a, input dw_t b);
        case (op)
            4'b0001, 4'b1001: return a + b;
            4'b0010, 4'b1010: return a - b;
            default:          return a;
        endcase
    endfunction

    // Reference model: pushes the expected issue (if any) and expected PHV.
    task automatic expect_txn(input phv_t p, input act_t a, input bit alu_ok, input bit push_out);
        logic [3:0] op = a[24:21];
        int   s1 = int'(a[20:16]);
        int   s2 = int'(a[15:11]);
        bit   is_reg = (op == 4'b0001) || (op == 4'b0010);
        bit   is_imm = (op == 4'b1001) || (op == 4'b1010);
        bit   nop = (s1 >= NC) || (op == 4'b0000) || (is_reg && s2 >= NC);
        issue_t it;
        phv_t e = p;
        if (!nop) begin
            it.op1 = cont_of(p, s1);
            it.op2 = is_reg ? cont_of(p, s2) : (is_imm ? dw_t'(a[15:0]) : '0);
            it.act = a;
            exp_iss.push_back(it);
            if (alu_ok) e = set_cont(p, s1, alu_fn(op, it.op1, it.op2));
        end
        if (push_out) exp_phv.push_back(e);
    endtask

    task automatic monitor();
        issue_t it;
        if (rst) begin
            prev_valid = 1'b0;
            return;
        end
        if (alu_action_valid) begin
            n_issue++;
            iss_cyc = cyc;
            check("issue_expected", exp_iss.size() != 0, 1);
            if (exp_iss.size() != 0) begin
                it = exp_iss.pop_front();
                check("operand_1", alu_operand_1_out, it.op1);
                check("operand_2", alu_operand_2_out, it.op2);
                check("action_out", alu_action_out, it.act);
            end
            if (alu_en) begin
                alu_cnt = 3;
                alu_res = alu_fn(alu_action_out[24:21], alu_operand_1_out, alu_operand_2_out);
            end
        end
        if (err_timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (phv_out_valid && !prev_valid) out_cyc = cyc;
        if (prev_valid && !prev_ready) begin
            check("hold_valid", phv_out_valid, 1);
            check("hold_phv", phv_out, prev_phv);
            check("hold_in_ready", phv_in_ready, 0);
        end
        if (phv_in_valid && phv_in_ready) begin
            n_acc++;
            acc_cyc = cyc;
        end
        if (phv_out_valid && phv_out_ready) begin
            n_out++;
            check("phv_expected", exp_phv.size() != 0, 1);
            if (exp_phv.size() != 0) check("phv_out", phv_out, exp_phv.pop_front());
        end
        prev_valid = phv_out_valid;
        prev_ready = phv_out_ready;
        prev_phv   = phv_out;
    endtask

    task automatic cycle();
        @(negedge clk);
        rst           = rst_nx;
        phv_in        = phv_nx;
        action_in     = act_nx;
        phv_in_valid  = valid_nx;
        phv_out_ready = ready_nx;
        alu_container_in_valid = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_container_in_valid = 1'b1;
                alu_container_in       = alu_res;
            end
        end
        #1;
        cyc++;
        monitor();
    endtask

    task automatic send(input phv_t p, input act_t a, input bit alu_ok, input bit push_out);
        int start = n_acc;
        expect_txn(p, a, alu_ok, push_out);
        phv_nx   = p;
        act_nx   = a;
        valid_nx = 1'b1;
        for (int k = 0; k < 50 && n_acc == start; k++) cycle();
        valid_nx = 1'b0;
        check("accept", n_acc - start, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && !(exp_phv.size() == 0 && phv_in_ready); k++) cycle();
        check("drain", exp_phv.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        phv_t base, p;
        int   i0, t0, o0, a0, rel;

        rst = 1'b1;
        phv_in = '0;
        action_in = '0;
        phv_in_valid = 1'b0;
        phv_out_ready = 1'b1;
        alu_container_in = '0;
        alu_container_in_valid = 1'b0;

        // Reset state.
        rst_nx = 1'b1;
        repeat (3) cycle();
        rst_nx = 1'b0;
        cycle();
        check("rst_phv_out_valid", phv_out_valid, 0);
        check("rst_alu_valid", alu_action_valid, 0);
        check("rst_phv_out", phv_out, 0);
        check("rst_operand_1", alu_operand_1_out, 0);
        check("rst_in_ready", phv_in_ready, 1);

        // Stale ALU response while idle must be ignored.
        alu_res = dw_t'(48'h0000_dead_beef);
        alu_cnt = 2;
        repeat (3) cycle();
        check("stale_valid", phv_out_valid, 0);
        check("stale_phv", phv_out, 0);

        base = '0;
        for (int i = 0; i < NC; i++) base = set_cont(base, i, dw_t'(1000 + i));

        // 1. Register add: cont2 = 10 + 7.
        p = set_cont(set_cont(base, 2, 48'd10), 5, 48'd7);
        i0 = n_issue; t0 = n_to;
        send(p, mk_act(4'b0001, 5'd2, {5'd5, 11'd0}), 1, 1);
        a0 = acc_cyc;
        wait_idle();
        check("add_issues", n_issue - i0, 1);
        check("add_latency", out_cyc - a0, 5);
        check("add_no_timeout", n_to - t0, 0);

        // 2. Immediate sub: cont0 = 100 - 0x28.
        p = set_cont(base, 0, 48'd100);
        send(p, mk_act(4'b1010, 5'd0, 16'h0028), 1, 1);
        a0 = acc_cyc;
        wait_idle();
        check("subi_latency", out_cyc - a0, 5);

        // 3. NOPs and range boundaries.
        i0 = n_issue;
        send(base, mk_act(4'b0000, 5'd2, {5'd3, 11'd0}), 1, 1);
        a0 = acc_cyc;
        wait_idle();
        check("nop_op_latency", out_cyc - a0, 1);
        send(base, mk_act(4'b0001, 5'd9, {5'd1, 11'd0}), 1, 1);
        a0 = acc_cyc;
        wait_idle();
        check("nop_src1_latency", out_cyc - a0, 1);
        send(base, mk_act(4'b0010, 5'd1, {5'd8, 11'd0}), 1, 1);
        wait_idle();
        check("nop_only", n_issue - i0, 0);
        send(base, mk_act(4'b1001, 5'd7, 16'hffff), 1, 1);
        wait_idle();
        send(base, mk_act(4'b0011, 5'd3, 16'hffff), 1, 1);
        wait_idle();
        check("boundary_issues", n_issue - i0, 2);

        // 4. ALU silent: timeout, PHV unchanged.
        alu_en = 1'b0;
        t0 = n_to;
        send(base, mk_act(4'b0001, 5'd1, {5'd4, 11'd0}), 0, 1);
        wait_idle();
        alu_en = 1'b1;
        check("timeout_count", n_to - t0, 1);
        check("timeout_delay", to_cyc - iss_cyc, TO + 1);

        // 5. Backpressure on the output; second PHV waits for ready.
        ready_nx = 1'b0;
        p = set_cont(set_cont(base, 6, 48'h7fff_ffff_ffff), 7, 48'd3);
        send(p, mk_act(4'b0001, 5'd6, {5'd7, 11'd0}), 1, 1);
        for (int k = 0; k < 50 && !phv_out_valid; k++) cycle();
        check("bp_valid_seen", phv_out_valid, 1);
        p = set_cont(base, 4, 48'd55);
        expect_txn(p, mk_act(4'b1001, 5'd4, 16'd5), 1, 1);
        phv_nx = p;
        act_nx = mk_act(4'b1001, 5'd4, 16'd5);
        valid_nx = 1'b1;
        a0 = n_acc;
        repeat (5) cycle();
        check("bp_no_accept", n_acc - a0, 0);
        ready_nx = 1'b1;
        rel = cyc + 1;
        for (int k = 0; k < 20 && n_acc == a0; k++) cycle();
        valid_nx = 1'b0;
        check("bp_accept", n_acc - a0, 1);
        check("bp_bubble", acc_cyc - rel, 1);
        wait_idle();

        // 6. Reset during WAIT; late ALU result ignored.
        i0 = n_issue; t0 = n_to; o0 = n_out;
        p = set_cont(set_cont(base, 3, 48'd20), 4, 48'd22);
        send(p, mk_act(4'b0001, 5'd3, {5'd4, 11'd0}), 1, 0);
        for (int k = 0; k < 20 && n_issue == i0; k++) cycle();
        check("rst_issue_seen", n_issue - i0, 1);
        rst_nx = 1'b1;
        cycle();
        rst_nx = 1'b0;
        cycle();
        check("mid_rst_valid", phv_out_valid, 0);
        check("mid_rst_phv", phv_out, 0);
        check("mid_rst_op1", alu_operand_1_out, 0);
        check("mid_rst_op2", alu_operand_2_out, 0);
        check("mid_rst_action", alu_action_out, 0);
        repeat (6) cycle();
        check("mid_rst_no_out", n_out - o0, 0);
        check("mid_rst_no_timeout", n_to - t0, 0);
        check("mid_rst_phv_late", phv_out, 0);
        p = set_cont(set_cont(base, 2, 48'd10), 5, 48'd7);
        send(p, mk_act(4'b0001, 5'd2, {5'd5, 11'd0}), 1, 1);
        a0 = acc_cyc;
        wait_idle();
        check("post_rst_latency", out_cyc - a0, 5);
        check("issue_queue_empty", exp_iss.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
